// File: rtl/active_list_if.sv
// Active list port bundle: rename allocation, writeback,
// squash and graduation signals between the ROB and the core.
interface active_list_if #(
  parameter int AL_SIZE = 32,
  parameter int PREG_W  = 6
);
  localparam int IDX_W = $clog2(AL_SIZE);

  logic              alloc_valid;
  logic              alloc_uses_rd;
  logic [PREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_old_rd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;

  logic              wb0_valid;
  logic [IDX_W-1:0]  wb0_al_idx;
  logic              wb1_valid;
  logic [IDX_W-1:0]  wb1_al_idx;

  logic              squash_valid;
  logic [IDX_W-1:0]  squash_al_idx;

  logic              grad_valid;
  logic [IDX_W-1:0]  grad_al_idx;
  logic              grad_uses_rd;
  logic [PREG_W-1:0] grad_rd;
  logic [PREG_W-1:0] grad_old_rd;

  logic [IDX_W:0]    count;
  logic              empty;

  modport master (
    output alloc_valid, alloc_uses_rd,
    output alloc_rd, alloc_old_rd,
    input  alloc_ready, alloc_idx,
    output wb0_valid, wb0_al_idx,
    output wb1_valid, wb1_al_idx,
    output squash_valid, squash_al_idx,
    input  grad_valid, grad_al_idx,
    input  grad_uses_rd, grad_rd,
    input  grad_old_rd, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_uses_rd,
    input  alloc_rd, alloc_old_rd,
    output alloc_ready, alloc_idx,
    input  wb0_valid, wb0_al_idx,
    input  wb1_valid, wb1_al_idx,
    input  squash_valid, squash_al_idx,
    output grad_valid, grad_al_idx,
    output grad_uses_rd, grad_rd,
    output grad_old_rd, count, empty
  );
endinterface

// File: rtl/active_list.sv
// In-order active list (reorder buffer): allocates at tail,
// completes via two writeback ports, retires from head.
module active_list #(
  parameter int AL_SIZE = 32,
  parameter int PREG_W  = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  active_list_if.slave al
);
  localparam int IDX_W = $clog2(AL_SIZE);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   ptr_t;

  typedef struct packed {
    logic              uses_rd;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] old_rd;
  } ent_t;

  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [AL_SIZE-1:0] done_q, done_d;
  ent_t             ent_q [AL_SIZE];
  ent_t             ent_d [AL_SIZE];
  logic             gv_q, gv_d;
  idx_t             gidx_q, gidx_d;
  ent_t             gent_q, gent_d;

  ptr_t count;
  logic full;
  logic empty;
  idx_t head_i;
  idx_t tail_i;

  assign count  = tail_q - head_q;
  assign full   = (count == ptr_t'(AL_SIZE));
  assign empty  = (count == '0);
  assign head_i = head_q[IDX_W-1:0];
  assign tail_i = tail_q[IDX_W-1:0];

  // Distance of an index from the head (age order).
  function automatic idx_t age(idx_t i, idx_t h);
    return i - h;
  endfunction

  function automatic logic live(idx_t i, idx_t h, ptr_t c);
    return {1'b0, age(i, h)} < c;
  endfunction

  idx_t sq_off;
  ptr_t sq_ext;
  logic sq_hit;
  logic wb0_ok;
  logic wb1_ok;
  logic grad_fire;
  logic alloc_fire;

  assign sq_off = age(al.squash_al_idx, head_i);
  assign sq_ext = {1'b0, sq_off};
  assign sq_hit = al.squash_valid
    && live(al.squash_al_idx, head_i, count);

  // Writebacks to squashed-away entries are dropped.
  assign wb0_ok = al.wb0_valid
    && live(al.wb0_al_idx, head_i, count)
    && (!sq_hit
        || age(al.wb0_al_idx, head_i) <= sq_off);
  assign wb1_ok = al.wb1_valid
    && live(al.wb1_al_idx, head_i, count)
    && (!sq_hit
        || age(al.wb1_al_idx, head_i) <= sq_off);

  assign grad_fire  = !empty && done_q[head_i];
  assign alloc_fire = al.alloc_valid && !full
    && !al.squash_valid;

  // Next-state: completion, retirement, squash, allocation.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    ent_d  = ent_q;
    gv_d   = 1'b0;
    gidx_d = gidx_q;
    gent_d = gent_q;
    if (wb0_ok) done_d[al.wb0_al_idx] = 1'b1;
    if (wb1_ok) done_d[al.wb1_al_idx] = 1'b1;
    if (grad_fire) begin
      gv_d   = 1'b1;
      gidx_d = head_i;
      gent_d = ent_q[head_i];
      head_d = head_q + ptr_t'(1);
    end
    if (sq_hit) begin
      tail_d = head_q + sq_ext + ptr_t'(1);
    end else if (alloc_fire) begin
      ent_d[tail_i].uses_rd = al.alloc_uses_rd;
      ent_d[tail_i].rd      = al.alloc_rd;
      ent_d[tail_i].old_rd  = al.alloc_old_rd;
      done_d[tail_i]        = 1'b0;
      tail_d                = tail_q + ptr_t'(1);
    end
  end

  // Control state and graduation outputs, sync reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
      gv_q   <= 1'b0;
      gidx_q <= '0;
      gent_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
      gv_q   <= gv_d;
      gidx_q <= gidx_d;
      gent_q <= gent_d;
    end
  end

  // Entry payload needs no reset: done bits gate its use.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign al.alloc_ready  = !full;
  assign al.alloc_idx    = tail_i;
  assign al.count        = count;
  assign al.empty        = empty;
  assign al.grad_valid   = gv_q;
  assign al.grad_al_idx  = gidx_q;
  assign al.grad_uses_rd = gent_q.uses_rd;
  assign al.grad_rd      = gent_q.rd;
  assign al.grad_old_rd  = gent_q.old_rd;
endmodule

// File: tb/tb_active_list.sv
// Bench for active_list: queue-based reference model
// checked every cycle plus directed literal checks.
module tb_active_list;
  localparam int N  = 32;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  active_list_if #(.AL_SIZE(N), .PREG_W(PW)) bus ();
  active_list #(.AL_SIZE(N), .PREG_W(PW)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .al(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int idx;
    bit uses;
    int rd;
    int old;
    bit done;
  } m_ent_t;

  m_ent_t q[$];
  int nxt;
  bit mg_v;
  int mg_idx, mg_uses, mg_rd, mg_old;
  int glog[$];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, exp);
  endtask

  function automatic int find(int i);
    foreach (q[k]) if (q[k].idx == i) return k;
    return -1;
  endfunction

  function automatic int glog_at(int k);
    if (k < glog.size()) return glog[k];
    return -1;
  endfunction

  // Reference: program-order list of live instructions.
  task automatic model_step();
    int pre_sz;
    int sp;
    int p;
    bit gv;
    m_ent_t ge;
    if (!n_rst) begin
      q.delete();
      nxt = 0;
      mg_v = 0;
      mg_idx = 0; mg_uses = 0; mg_rd = 0; mg_old = 0;
      return;
    end
    pre_sz = q.size();
    gv = (pre_sz > 0) && q[0].done;
    if (gv) ge = q[0];
    sp = -1;
    if (bus.squash_valid)
      sp = find(int'(bus.squash_al_idx));
    if (bus.wb0_valid) begin
      p = find(int'(bus.wb0_al_idx));
      if (p >= 0 && (sp < 0 || p <= sp)) q[p].done = 1;
    end
    if (bus.wb1_valid) begin
      p = find(int'(bus.wb1_al_idx));
      if (p >= 0 && (sp < 0 || p <= sp)) q[p].done = 1;
    end
    if (sp >= 0) begin
      while (q.size() > sp + 1) void'(q.pop_back());
      nxt = (int'(bus.squash_al_idx) + 1) % N;
    end
    if (gv) begin
      void'(q.pop_front());
      mg_v = 1;
      mg_idx = ge.idx; mg_uses = ge.uses;
      mg_rd = ge.rd; mg_old = ge.old;
    end else begin
      mg_v = 0;
    end
    if (bus.alloc_valid && pre_sz < N
        && !bus.squash_valid) begin
      q.push_back('{nxt, bus.alloc_uses_rd,
                    int'(bus.alloc_rd),
                    int'(bus.alloc_old_rd), 1'b0});
      nxt = (nxt + 1) % N;
    end
  endtask

  task automatic compare();
    check("count", int'(bus.count), q.size());
    check("empty", int'(bus.empty), int'(q.size() == 0));
    check("alloc_ready", int'(bus.alloc_ready),
          int'(q.size() < N));
    check("alloc_idx", int'(bus.alloc_idx), nxt);
    check("grad_valid", int'(bus.grad_valid), int'(mg_v));
    check("grad_al_idx", int'(bus.grad_al_idx), mg_idx);
    check("grad_uses_rd", int'(bus.grad_uses_rd), mg_uses);
    check("grad_rd", int'(bus.grad_rd), mg_rd);
    check("grad_old_rd", int'(bus.grad_old_rd), mg_old);
    if (bus.grad_valid) glog.push_back(int'(bus.grad_al_idx));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    bus.alloc_valid   = 0;
    bus.alloc_uses_rd = 0;
    bus.alloc_rd      = '0;
    bus.alloc_old_rd  = '0;
    bus.wb0_valid     = 0;
    bus.wb0_al_idx    = '0;
    bus.wb1_valid     = 0;
    bus.wb1_al_idx    = '0;
    bus.squash_valid  = 0;
    bus.squash_al_idx = '0;
  endtask

  task automatic do_reset();
    idle_in();
    n_rst = 0;
    cyc();
    cyc();
    n_rst = 1;
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_ready", int'(bus.alloc_ready), 1);
    check("rst_idx", int'(bus.alloc_idx), 0);
    check("rst_gv", int'(bus.grad_valid), 0);
    check("rst_grd", int'(bus.grad_old_rd), 0);
  endtask

  task automatic alloc(int rd, int old, bit uses);
    bus.alloc_valid   = 1;
    bus.alloc_uses_rd = uses;
    bus.alloc_rd      = PW'(rd);
    bus.alloc_old_rd  = PW'(old);
    cyc();
    bus.alloc_valid = 0;
  endtask

  task automatic wb(bit v0, int i0, bit v1, int i1);
    bus.wb0_valid  = v0;
    bus.wb0_al_idx = 5'(i0);
    bus.wb1_valid  = v1;
    bus.wb1_al_idx = 5'(i1);
    cyc();
    bus.wb0_valid = 0;
    bus.wb1_valid = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    idle_in();
    n_rst = 0;
    nxt = 0;

    // 1: fill to full, reject the 33rd
    do_reset();
    for (int i = 0; i < N; i++) begin
      check("t1_idx", int'(bus.alloc_idx), i);
      alloc(i + 32, i, 1'b1);
    end
    check("t1_count", int'(bus.count), 32);
    check("t1_ready", int'(bus.alloc_ready), 0);
    alloc(1, 1, 1'b1);
    check("t1_count33", int'(bus.count), 32);

    // 2: out-of-order completion, in-order grads
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i + 32, i, i != 2);
    wb(1, 2, 0, 0);
    check("t2_nograd_a", int'(bus.grad_valid), 0);
    wb(1, 3, 0, 0);
    check("t2_nograd_b", int'(bus.grad_valid), 0);
    wb(1, 0, 1, 1);
    check("t2_nograd_c", int'(bus.grad_valid), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t2_gv", int'(bus.grad_valid), 1);
      check("t2_gidx", int'(bus.grad_al_idx), k);
      check("t2_gold", int'(bus.grad_old_rd), k);
    end
    cyc();
    check("t2_empty", int'(bus.empty), 1);

    // 3: wrap-around of head and tail
    do_reset();
    for (int i = 0; i < N; i++) alloc(i + 32, i, 1'b1);
    for (int k = 0; k < 15; k++) wb(1, 2 * k, 1, 2 * k + 1);
    idle(20);
    check("t3_count2", int'(bus.count), 2);
    for (int i = 0; i < 3; i++) begin
      check("t3_idx", int'(bus.alloc_idx), i);
      alloc(10 + i, 20 + i, 1'b1);
    end
    glog.delete();
    wb(1, 30, 0, 0);
    wb(1, 31, 0, 0);
    wb(1, 0, 0, 0);
    idle(4);
    check("t3_ngrad", glog.size(), 3);
    check("t3_g0", glog_at(0), 30);
    check("t3_g1", glog_at(1), 31);
    check("t3_g2", glog_at(2), 0);
    check("t3_count", int'(bus.count), 2);

    // 4: squash with same-cycle alloc and wb
    do_reset();
    for (int i = 0; i < 8; i++) alloc(i + 32, i, 1'b1);
    bus.alloc_valid   = 1;
    bus.alloc_rd      = 6'd50;
    bus.alloc_old_rd  = 6'd5;
    bus.squash_valid  = 1;
    bus.squash_al_idx = 5'd3;
    bus.wb1_valid     = 1;
    bus.wb1_al_idx    = 5'd5;
    cyc();
    idle_in();
    check("t4_count", int'(bus.count), 4);
    check("t4_idx", int'(bus.alloc_idx), 4);
    alloc(40, 4, 1'b0);
    alloc(41, 5, 1'b1);
    idle(3);
    check("t4_nograd", int'(bus.grad_valid), 0);
    check("t4_count6", int'(bus.count), 6);

    // 5: squash at a done head
    do_reset();
    for (int i = 0; i < 3; i++) alloc(i + 32, i, 1'b1);
    wb(1, 0, 0, 0);
    bus.squash_valid  = 1;
    bus.squash_al_idx = 5'd0;
    cyc();
    idle_in();
    check("t5_gv", int'(bus.grad_valid), 1);
    check("t5_gidx", int'(bus.grad_al_idx), 0);
    check("t5_count", int'(bus.count), 0);
    check("t5_empty", int'(bus.empty), 1);
    check("t5_idx", int'(bus.alloc_idx), 1);

    // 6: writeback to non-live index is dropped
    do_reset();
    for (int i = 0; i < 5; i++) alloc(i + 32, i, 1'b1);
    wb(1, 9, 1, 9);
    for (int i = 5; i < 10; i++) alloc(i + 32, i, 1'b1);
    glog.delete();
    for (int i = 0; i < 5; i++) wb(1, i, 0, 0);
    idle(6);
    check("t6_ngrad", glog.size(), 5);
    check("t6_count", int'(bus.count), 5);
    check("t6_gv", int'(bus.grad_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
